int_sel_seq: RTL

//  Parametrised, handshaked successor to the exp range-reduction index selector.

---
 rtl/int_sel_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/int_sel_seq.sv
// Exp range reduction: q = floor(x/ln2) by shift-subtract against a constant,
// emitting clamped index k, remainder r and an overflow flag over valid/ready.
module int_sel_seq #(
   parameter int unsigned X_W    = 15,
   parameter int unsigned FRAC_W = 11,
   parameter int unsigned G      = 4,
   parameter int unsigned LN2_C  = 22713,
   parameter int unsigned K_W    = 5,
   parameter int unsigned K_MIN  = 1,
   parameter int unsigned K_MAX  = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [X_W-1:0]        x,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [K_W-1:0]        k,
   output logic [FRAC_W+G-1:0]   r,
   output logic                  ovf
);

   localparam int unsigned RW   = X_W + G;
   localparam int unsigned CW   = RW + K_W;
   localparam int unsigned R_W  = FRAC_W + G;
   localparam int unsigned IT_W = (K_W > 1) ? $clog2(K_W) : 1;

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [RW-1:0]     rem_q, rem_d;
   logic [IT_W-1:0]   it_q, it_d;
   logic [K_W-1:0]    q_q, q_d;
   logic              pre_ovf_q, pre_ovf_d;
   logic              fin_q, fin_d;
   logic [K_W-1:0]    k_q, k_d;
   logic [R_W-1:0]    r_q, r_d;
   logic              ovf_q, ovf_d;

   logic [RW-1:0]     xs;
   logic [CW-1:0]     sub;
   logic              ge;
   logic              q_ovf;

   assign xs    = {x, {G{1'b0}}};
   assign sub   = CW'(LN2_C) << it_q;
   assign ge    = CW'(rem_q) >= sub;
   assign q_ovf = pre_ovf_q || (q_q > K_W'(K_MAX));

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      it_d      = it_q;
      q_d       = q_q;
      pre_ovf_d = pre_ovf_q;
      fin_d     = fin_q;
      k_d       = k_q;
      r_d       = r_q;
      ovf_d     = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               rem_d     = xs;
               it_d      = IT_W'(K_W - 1);
               q_d       = '0;
               fin_d     = 1'b0;
               pre_ovf_d = CW'(xs) >= (CW'(LN2_C) << K_W);
               state_d   = DIV;
            end
         end
         DIV: begin
            if (!fin_q) begin
               if (ge) rem_d = rem_q - sub[RW-1:0];
               q_d[it_q] = ge;
               if (it_q == '0) fin_d = 1'b1;
               else            it_d  = it_q - 1'b1;
            end else begin
               // r is taken from the unclamped quotient's remainder
               ovf_d   = q_ovf;
               k_d     = q_ovf ? '0 :
                         (q_q < K_W'(K_MIN)) ? K_W'(K_MIN) : q_q;
               r_d     = q_ovf ? '0 : rem_q[R_W-1:0];
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (clr) begin
         state_d = IDLE;
         k_d     = k_q;
         r_d     = r_q;
         ovf_d   = ovf_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rem_q     <= '0;
         it_q      <= '0;
         q_q       <= '0;
         pre_ovf_q <= 1'b0;
         fin_q     <= 1'b0;
         k_q       <= '0;
         r_q       <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         it_q      <= it_d;
         q_q       <= q_d;
         pre_ovf_q <= pre_ovf_d;
         fin_q     <= fin_d;
         k_q       <= k_d;
         r_q       <= r_d;
         ovf_q     <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign k         = k_q;
   assign r         = r_q;
   assign ovf       = ovf_q;

endmodule
